// File: rtl/hard_interrupt_ctrl.sv
// Edge-triggered interrupt collector: synchronizes peripheral requests, latches them
// as pending and presents the highest-priority unmasked one to the CPU until acknowledged.
module hard_interrupt_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstIn,
  input  logic [3:0] irqIn,
  input  logic       maskWe,
  input  logic [3:0] maskData,
  input  logic       intAck,
  output logic [3:0] hardInterrupt,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_dly;
  logic [3:0] r_pending;
  logic [3:0] r_mask;
  logic [3:0] r_code;
  logic       r_busy;
  logic [1:0] r_cur_idx;
  state_t     r_state;

  state_t     w_next_state;
  logic [1:0] w_next_idx;
  logic [1:0] w_win_idx;
  logic [3:0] w_rise;
  logic [3:0] w_clr;
  logic [3:0] w_eligible;
  logic [3:0] w_code_d;
  logic       w_busy_d;

  // NOTE: these are a handful of flops, not a RAM, so every one of them is reset.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_dly <= '0;
    end else begin
      r_sync[0] <= irqIn;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_dly <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign w_eligible = r_pending & r_mask;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    w_win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_eligible[i]) w_win_idx = 2'(i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_cur_idx;
    w_clr        = 4'd0;
    w_code_d     = 4'd0;
    w_busy_d     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_next_state = ST_PRESENT;
          w_next_idx   = w_win_idx;
        end
      end
      ST_PRESENT: begin
        if (intAck) begin
          w_clr        = 4'b0001 << r_cur_idx;
          w_next_state = ST_GAP;
        end else begin
          w_code_d = {2'b00, r_cur_idx} + 4'd1;
          w_busy_d = 1'b1;
        end
      end
      ST_GAP:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state   <= ST_IDLE;
      r_cur_idx <= 2'd0;
      r_code    <= 4'd0;
      r_busy    <= 1'b0;
      r_pending <= 4'd0;
      r_mask    <= 4'd0;
    end else begin
      r_state   <= w_next_state;
      r_cur_idx <= w_next_idx;
      r_code    <= w_code_d;
      r_busy    <= w_busy_d;
      // A fresh edge on the line being cleared wins over the clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (maskWe) r_mask <= maskData;
    end
  end

  assign hardInterrupt = r_code;
  assign pending       = r_pending;
  assign busy          = r_busy;

endmodule

// File: tb/tb_hard_interrupt_ctrl.sv
// Scoreboard bench for hard_interrupt_ctrl: a cycle model predicts outputs each edge,
// a monitor compares them on the falling edge; directed checks cover latency corners.
module tb_hard_interrupt_ctrl;

  localparam int S = 2;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq = 4'hF;
  logic       mask_we = 1'b0;
  logic [3:0] mask_data = 4'd0;
  logic       int_ack = 1'b0;
  logic [3:0] hard_int;
  logic [3:0] pend;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       sb_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_pend = 4'd0;
  logic [3:0] m_mask = 4'd0;
  int         m_cur  = -1;
  bit         m_gap  = 1'b0;

  hard_interrupt_ctrl #(.SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rstIn        (rst),
    .irqIn        (irq),
    .maskWe       (mask_we),
    .maskData     (mask_data),
    .intAck       (int_ack),
    .hardInterrupt(hard_int),
    .pending      (pend),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 4'd0;
    m_mask = 4'd0;
    m_cur  = -1;
    m_gap  = 1'b0;
    hist   = {};
    repeat (S + 1) hist.push_back(4'd0);
  endtask

  // One clock edge of the reference behaviour, computed from pre-edge values.
  task automatic model_step();
    logic [3:0] rise, clr, elig;
    exp_t e;
    rise   = hist[S-1] & ~hist[S];
    clr    = 4'd0;
    elig   = m_pend & m_mask;
    e.code = 4'd0;
    e.busy = 1'b0;
    if (m_cur >= 0) begin
      if (int_ack) begin
        clr   = 4'(1 << m_cur);
        m_cur = -1;
        m_gap = 1'b1;
      end else begin
        e.code = 4'(m_cur + 1);
        e.busy = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (elig != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (elig[i]) begin
          m_cur = i;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_data;
    hist.push_front(irq);
    void'(hist.pop_back());
    e.pend = m_pend;
    sb_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
        sb_q = {};
        sb_q.push_back(exp_t'(0));
      end else begin
        model_step();
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_code", {4'd0, hard_int}, {4'd0, e.code});
        check("sb_pending", {4'd0, pend}, {4'd0, e.pend});
        check("sb_busy", {7'd0, busy}, {7'd0, e.busy});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 30 && busy !== 1'b1; k++) tick();
    check("busy_wait", {7'd0, busy}, 8'd1);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic service();
    wait_busy();
    ack_pulse();
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we   = 1'b1;
    mask_data = m;
    tick();
    mask_we   = 1'b0;
  endtask

  initial begin
    // Reset held with every request line high.
    repeat (3) tick();
    check("rst_code", {4'd0, hard_int}, 8'd0);
    check("rst_pending", {4'd0, pend}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("post_rst_pending", {4'd0, pend}, 8'h0F);
    check("post_rst_masked_code", {4'd0, hard_int}, 8'd0);
    irq = 4'd0;
    write_mask(4'hF);
    repeat (4) service();
    repeat (4) tick();
    check("drain_pending", {4'd0, pend}, 8'd0);

    // Single request latency.
    irq = 4'b0100;
    tick();
    irq = 4'd0;
    tick();
    tick();
    check("single_pending_t3", {4'd0, pend}, 8'h04);
    tick();
    tick();
    check("single_code_t5", {4'd0, hard_int}, 8'd3);
    ack_pulse();
    check("single_ack_code", {4'd0, hard_int}, 8'd0);
    check("single_ack_pending", {4'd0, pend}, 8'd0);

    // Priority freeze.
    repeat (2) tick();
    irq = 4'b1000;
    wait_busy();
    check("freeze_code_start", {4'd0, hard_int}, 8'd4);
    irq = 4'b1001;
    repeat (6) begin
      tick();
      check("freeze_code_hold", {4'd0, hard_int}, 8'd4);
    end
    ack_pulse();
    check("freeze_ack_drop", {4'd0, hard_int}, 8'd0);
    tick();
    check("freeze_gap_zero", {4'd0, hard_int}, 8'd0);
    wait_busy();
    check("freeze_next_code", {4'd0, hard_int}, 8'd1);
    ack_pulse();
    irq = 4'd0;
    repeat (3) tick();

    // Masking.
    write_mask(4'b1110);
    irq = 4'b0001;
    tick();
    irq = 4'd0;
    repeat (5) tick();
    check("mask_pending", {4'd0, pend}, 8'h01);
    check("mask_code_held", {4'd0, hard_int}, 8'd0);
    write_mask(4'hF);
    tick();
    tick();
    check("unmask_code", {4'd0, hard_int}, 8'd1);
    service();
    repeat (3) tick();

    // Acknowledge in IDLE, then set and clear on the same line in one edge.
    ack_pulse();
    check("idle_ack_busy", {7'd0, busy}, 8'd0);
    check("idle_ack_pending", {4'd0, pend}, 8'd0);
    irq = 4'b0010;
    tick();
    irq = 4'd0;
    wait_busy();
    check("line1_code", {4'd0, hard_int}, 8'd2);
    irq = 4'b0010;
    tick();
    irq = 4'd0;
    tick();
    ack_pulse();
    check("set_wins_pending", {4'd0, pend}, 8'h02);
    check("set_wins_code_drop", {4'd0, hard_int}, 8'd0);
    wait_busy();
    check("set_wins_represent", {4'd0, hard_int}, 8'd2);
    ack_pulse();
    repeat (3) tick();

    // Asynchronous reset while presenting.
    irq = 4'b0010;
    tick();
    irq = 4'd0;
    wait_busy();
    check("pre_rst_code", {4'd0, hard_int}, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_code", {4'd0, hard_int}, 8'd0);
    check("async_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    tick();
    rst = 1'b0;
    irq = 4'b0001;
    tick();
    irq = 4'd0;
    repeat (6) tick();
    check("rst_mask_cleared_pending", {4'd0, pend}, 8'h01);
    check("rst_mask_cleared_code", {4'd0, hard_int}, 8'd0);
    write_mask(4'hF);
    service();

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      irq       = irq ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15))
                         & 4'($urandom_range(0, 15)));
      mask_we   = ($urandom_range(0, 15) == 0);
      mask_data = 4'($urandom_range(0, 15));
      int_ack   = ($urandom_range(0, 2) == 0);
      tick();
    end
    irq     = 4'd0;
    mask_we = 1'b0;
    int_ack = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
